// File: rtl/ace_rd_req_dispatcher_pkg.sv
// Shared types for the ACE read-request dispatcher: FSM state encoding and AR field widths.
package ace_rd_req_dispatcher_pkg;

  localparam int AR_LEN_W = 8;
  localparam int TO_CNT_W = 16;

  typedef enum logic [1:0] {
    RDQ_IDLE  = 2'd0,
    RDQ_REQ   = 2'd1,
    RDQ_WRITE = 2'd2,
    RDQ_GAP   = 2'd3
  } rdq_state_e;

endpackage

// File: rtl/ace_rd_req_dispatcher.sv
// ACE slave read-path front stage: takes one AR request, asks the allocator for a descriptor,
// writes the captured AR fields into it. Optional allocation timeout: ACE_RD_REQ_TIMEOUT_EN.
module ace_rd_req_dispatcher
  import ace_rd_req_dispatcher_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 16,
  parameter int MAX_DESC   = 8,
  parameter int TO_CYCLES  = 256,
  localparam int DESC_IDX_WIDTH = $clog2(MAX_DESC)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]     ar_addr_i,
  input  logic [AR_LEN_W-1:0]       ar_len_i,
  input  logic [ID_WIDTH-1:0]       ar_id_i,
  output logic                      txn_valid_o,
  input  logic                      desc_alc_valid_i,
  input  logic [DESC_IDX_WIDTH-1:0] desc_alc_idx_i,
  output logic                      desc_wr_en_o,
  output logic [DESC_IDX_WIDTH-1:0] desc_wr_idx_o,
  output logic [ADDR_WIDTH-1:0]     desc_wr_addr_o,
  output logic [AR_LEN_W-1:0]       desc_wr_len_o,
  output logic [ID_WIDTH-1:0]       desc_wr_id_o,
  output logic [MAX_DESC-1:0]       busy_set_o,
  output logic                      alloc_timeout_o
);

  rdq_state_e                state_q;
  logic                      ar_ready_q;
  logic                      txn_valid_q;
  logic                      desc_wr_en_q;
  logic [DESC_IDX_WIDTH-1:0] desc_wr_idx_q;
  logic [ADDR_WIDTH-1:0]     desc_wr_addr_q;
  logic [AR_LEN_W-1:0]       desc_wr_len_q;
  logic [ID_WIDTH-1:0]       desc_wr_id_q;
  logic [MAX_DESC-1:0]       busy_set_q;
  logic [ADDR_WIDTH-1:0]     cap_addr_q;
  logic [AR_LEN_W-1:0]       cap_len_q;
  logic [ID_WIDTH-1:0]       cap_id_q;
  logic [MAX_DESC-1:0]       busy_set_d;
  logic                      req_accept_s;

  assign req_accept_s = (state_q == RDQ_IDLE) && ar_valid_i;

  // One-hot decode of the granted index for the busy_set pulse
  always_comb begin
    busy_set_d = '0;
    for (int i = 0; i < MAX_DESC; i++) begin
      busy_set_d[i] = (desc_alc_idx_i == DESC_IDX_WIDTH'(i));
    end
  end

  // Request FSM with registered outputs; write strobes default low every cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= RDQ_IDLE;
      ar_ready_q     <= 1'b1;
      txn_valid_q    <= 1'b0;
      desc_wr_en_q   <= 1'b0;
      desc_wr_idx_q  <= '0;
      desc_wr_addr_q <= '0;
      desc_wr_len_q  <= '0;
      desc_wr_id_q   <= '0;
      busy_set_q     <= '0;
      cap_addr_q     <= '0;
      cap_len_q      <= '0;
      cap_id_q       <= '0;
    end else begin
      desc_wr_en_q <= 1'b0;
      busy_set_q   <= '0;
      case (state_q)
        RDQ_IDLE: begin
          if (ar_valid_i) begin
            cap_addr_q  <= ar_addr_i;
            cap_len_q   <= ar_len_i;
            cap_id_q    <= ar_id_i;
            ar_ready_q  <= 1'b0;
            txn_valid_q <= 1'b1;
            state_q     <= RDQ_REQ;
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        RDQ_REQ: begin
          // With no free descriptor we simply wait here, which backpressures AR
          if (desc_alc_valid_i) begin
            txn_valid_q    <= 1'b0;
            desc_wr_en_q   <= 1'b1;
            busy_set_q     <= busy_set_d;
            desc_wr_idx_q  <= desc_alc_idx_i;
            desc_wr_addr_q <= cap_addr_q;
            desc_wr_len_q  <= cap_len_q;
            desc_wr_id_q   <= cap_id_q;
            state_q        <= RDQ_WRITE;
          end else begin
            txn_valid_q <= 1'b1;
          end
        end
        RDQ_WRITE: begin
          state_q <= RDQ_GAP;
        end
        RDQ_GAP: begin
          // One dead cycle guarantees the allocator sees a fresh txn_valid edge
          ar_ready_q <= 1'b1;
          state_q    <= RDQ_IDLE;
        end
        default: begin
          ar_ready_q  <= 1'b1;
          txn_valid_q <= 1'b0;
          state_q     <= RDQ_IDLE;
        end
      endcase
    end
  end

`ifdef ACE_RD_REQ_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic                alloc_timeout_q;

  // Allocation watchdog: counts REQ cycles, flag is sticky until reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      to_cnt_q        <= '0;
      alloc_timeout_q <= 1'b0;
    end else if (req_accept_s) begin
      to_cnt_q <= '0;
    end else if (state_q == RDQ_REQ) begin
      to_cnt_q <= to_cnt_q + 16'd1;
      if (to_cnt_q == TO_CNT_W'(TO_CYCLES - 1)) begin
        alloc_timeout_q <= 1'b1;
      end
    end else begin
      to_cnt_q <= to_cnt_q;
    end
  end

  assign alloc_timeout_o = alloc_timeout_q;
`else
  logic unused_s;
  assign unused_s        = req_accept_s ^ (TO_CYCLES == 0);
  assign alloc_timeout_o = 1'b0;
`endif

  assign ar_ready_o     = ar_ready_q;
  assign txn_valid_o    = txn_valid_q;
  assign desc_wr_en_o   = desc_wr_en_q;
  assign desc_wr_idx_o  = desc_wr_idx_q;
  assign desc_wr_addr_o = desc_wr_addr_q;
  assign desc_wr_len_o  = desc_wr_len_q;
  assign desc_wr_id_o   = desc_wr_id_q;
  assign busy_set_o     = busy_set_q;

endmodule

// File: tb/tb_ace_rd_req_dispatcher.sv
// Directed self-checking bench for ace_rd_req_dispatcher; honours ACE_RD_REQ_TIMEOUT_EN
// (instantiated with TO_CYCLES=16).
module tb_ace_rd_req_dispatcher;

  localparam int AW = 64;
  localparam int IW = 16;
  localparam int ND = 8;
  localparam int XW = 3;
`ifdef ACE_RD_REQ_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ar_valid;
  logic          ar_ready;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [IW-1:0] ar_id;
  logic          txn_valid;
  logic          alc_valid;
  logic [XW-1:0] alc_idx;
  logic          wr_en;
  logic [XW-1:0] wr_idx;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_len;
  logic [IW-1:0] wr_id;
  logic [ND-1:0] busy_set;
  logic          alloc_to;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ace_rd_req_dispatcher #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_DESC(ND), .TO_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_id_i(ar_id),
    .txn_valid_o(txn_valid),
    .desc_alc_valid_i(alc_valid), .desc_alc_idx_i(alc_idx),
    .desc_wr_en_o(wr_en), .desc_wr_idx_o(wr_idx),
    .desc_wr_addr_o(wr_addr), .desc_wr_len_o(wr_len), .desc_wr_id_o(wr_id),
    .busy_set_o(busy_set), .alloc_timeout_o(alloc_to)
  );

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present_ar(input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] i);
    ar_valid = 1'b1;
    ar_addr  = a;
    ar_len   = l;
    ar_id    = i;
  endtask

  task automatic grant(input logic [XW-1:0] idx);
    alc_valid = 1'b1;
    alc_idx   = idx;
    tick();
    alc_valid = 1'b0;
    alc_idx   = '0;
  endtask

  initial begin
    int bad_txn, bad_rdy, bad_wr;
    reset = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_id = '0;
    alc_valid = 1'b0; alc_idx = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_vec("rst_ar_ready", 64'(ar_ready), 64'd1);
    chk_vec("rst_txn",      64'(txn_valid), 64'd0);
    chk_vec("rst_wr_en",    64'(wr_en), 64'd0);
    chk_vec("rst_busy",     64'(busy_set), 64'd0);
    chk_vec("rst_wr_addr",  wr_addr, 64'd0);
    chk_vec("rst_timeout",  64'(alloc_to), 64'd0);

    // 1: single request, grant idx 2 after 4 REQ cycles
    present_ar(64'h1000, 8'd3, 16'd5);
    tick();
    ar_valid = 1'b0;
    chk_vec("t1_txn_up",   64'(txn_valid), 64'd1);
    chk_vec("t1_rdy_down", 64'(ar_ready), 64'd0);
    bad_wr = 0;
    repeat (3) begin
      tick();
      if (wr_en !== 1'b0 || txn_valid !== 1'b1) bad_wr++;
    end
    chk_vec("t1_wait", 64'(bad_wr), 64'd0);
    grant(3'd2);
    chk_vec("t1_wr_en",  64'(wr_en), 64'd1);
    chk_vec("t1_wr_idx", 64'(wr_idx), 64'd2);
    chk_vec("t1_addr",   wr_addr, 64'h1000);
    chk_vec("t1_len",    64'(wr_len), 64'd3);
    chk_vec("t1_id",     64'(wr_id), 64'd5);
    chk_vec("t1_busy",   64'(busy_set), 64'h04);
    chk_vec("t1_txn_dn", 64'(txn_valid), 64'd0);
    tick();
    chk_vec("t1_gap_wr",   64'(wr_en), 64'd0);
    chk_vec("t1_gap_busy", 64'(busy_set), 64'd0);
    chk_vec("t1_gap_rdy",  64'(ar_ready), 64'd0);
    chk_vec("t1_hold_adr", wr_addr, 64'h1000);
    tick();
    chk_vec("t1_idle_rdy", 64'(ar_ready), 64'd1);

    // 2: back-to-back with ar_valid held
    present_ar(64'hA000, 8'd1, 16'h11);
    tick();
    present_ar(64'hB000, 8'd7, 16'h22);
    chk_vec("t2a_txn", 64'(txn_valid), 64'd1);
    grant(3'd0);
    chk_vec("t2a_busy", 64'(busy_set), 64'h01);
    chk_vec("t2a_addr", wr_addr, 64'hA000);
    chk_vec("t2a_rdy",  64'(ar_ready), 64'd0);
    tick();
    chk_vec("t2_gap_txn", 64'(txn_valid), 64'd0);
    chk_vec("t2_gap_rdy", 64'(ar_ready), 64'd0);
    tick();
    chk_vec("t2_idle_txn", 64'(txn_valid), 64'd0);
    chk_vec("t2_idle_rdy", 64'(ar_ready), 64'd1);
    tick();
    ar_valid = 1'b0;
    chk_vec("t2b_txn", 64'(txn_valid), 64'd1);
    chk_vec("t2b_rdy", 64'(ar_ready), 64'd0);
    grant(3'd1);
    chk_vec("t2b_busy", 64'(busy_set), 64'h02);
    chk_vec("t2b_addr", wr_addr, 64'hB000);
    chk_vec("t2b_len",  64'(wr_len), 64'd7);
    chk_vec("t2b_id",   64'(wr_id), 64'h22);
    repeat (2) tick();

    // 3: starvation for 1000 cycles, then grant idx 7
    present_ar(64'hC0DE_0000, 8'd15, 16'hBEEF);
    tick();
    ar_valid = 1'b0;
    bad_txn = 0; bad_rdy = 0; bad_wr = 0;
    repeat (1000) begin
      tick();
      if (txn_valid !== 1'b1) bad_txn++;
      if (ar_ready !== 1'b0) bad_rdy++;
      if (wr_en !== 1'b0) bad_wr++;
    end
    chk_vec("t3_txn_held", 64'(bad_txn), 64'd0);
    chk_vec("t3_rdy_low",  64'(bad_rdy), 64'd0);
    chk_vec("t3_no_wr",    64'(bad_wr), 64'd0);
    grant(3'd7);
    chk_vec("t3_busy", 64'(busy_set), 64'h80);
    chk_vec("t3_id",   64'(wr_id), 64'hBEEF);
    repeat (2) tick();

    // 4: spurious grant while idle
    grant(3'd3);
    chk_vec("t4_no_wr",   64'(wr_en), 64'd0);
    chk_vec("t4_busy",    64'(busy_set), 64'd0);
    chk_vec("t4_idx",     64'(wr_idx), 64'd7);
    chk_vec("t4_txn",     64'(txn_valid), 64'd0);
    tick();
    chk_vec("t4_rdy",     64'(ar_ready), 64'd1);
    chk_vec("t4_no_wr2",  64'(wr_en), 64'd0);

    // 5: reset while in REQ
    present_ar(64'hD000, 8'd2, 16'd9);
    tick();
    ar_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_vec("t5_txn",  64'(txn_valid), 64'd0);
    chk_vec("t5_rdy",  64'(ar_ready), 64'd1);
    chk_vec("t5_idx",  64'(wr_idx), 64'd0);
    chk_vec("t5_addr", wr_addr, 64'd0);
    chk_vec("t5_id",   64'(wr_id), 64'd0);
    chk_vec("t5_to",   64'(alloc_to), 64'd0);
    grant(3'd4);
    chk_vec("t5_dropped", 64'(wr_en), 64'd0);

    // 6: allocation timeout after 16 REQ cycles, sticky past the grant
    present_ar(64'hE000, 8'd0, 16'd1);
    tick();
    ar_valid = 1'b0;
    repeat (15) tick();
    chk_vec("t6_pre_to", 64'(alloc_to), 64'd0);
    tick();
    chk_vec("t6_to", 64'(alloc_to), 64'(TO_EXP));
    grant(3'd5);
    chk_vec("t6_busy", 64'(busy_set), 64'h20);
    repeat (3) tick();
    chk_vec("t6_sticky", 64'(alloc_to), 64'(TO_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
